dac_waveform_player: RTL and testbench

//  PS->DAC path. Packs ps_axis_width beats from the CPU into 128-bit DAC words and stores them in an on-chip waveform RAM.

---
 rtl/rfsoc_config_pkg.sv | 25 ++
 rtl/dac_waveform_player_packer.sv | 37 +++
 rtl/dac_waveform_player.sv | 142 ++++++++++++++
 tb/tb_dac_waveform_player.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rfsoc_config_pkg.sv
// Shared RFSoC control definitions: gpio_ctrl bit map, PS stream width and
// the DAC player state type.
package rfsoc_config;

    localparam int ps_axis_width    = 32;

    localparam int trigger_line     = 0;
    localparam int dac_load_enable  = 1;
    localparam int dac_buffer_clear = 2;
    localparam int dac_loop_mode    = 3;

    localparam int dac_word_width   = 128;

    // IDLE  | nothing loading or playing, tdata held at zero
    // LOAD  | accepting PS beats into the waveform RAM
    // ARMED | waveform present, waiting for a trigger edge
    // PLAY  | streaming RAM words to the DAC
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        ARMED = 2'd2,
        PLAY  = 2'd3
    } dac_play_state_t;

endpackage

// File: rtl/dac_waveform_player_packer.sv
// Packs ps_axis_width beats into one DAC word, first beat in the lowest lane.
// abort drops any partially collected word.
module dac_beat_packer
    import rfsoc_config::*;
(
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         abort,
    input  logic                         beat_valid,
    input  logic [ps_axis_width-1:0]     beat_data,
    output logic                         word_valid,
    output logic [dac_word_width-1:0]    word_data
);
    localparam int BEATS   = dac_word_width / ps_axis_width;
    localparam int CNT_W   = $clog2(BEATS);
    localparam int PART_W  = dac_word_width - ps_axis_width;

    logic [CNT_W-1:0]  count;
    logic [PART_W-1:0] partial;
    logic              at_last;

    assign at_last    = (count == CNT_W'(BEATS - 1));
    assign word_valid = beat_valid && at_last && !abort;
    assign word_data  = {beat_data, partial};

    // New beats enter at the top lane; after BEATS-1 shifts the first one sits at the bottom.
    always_ff @(posedge clk) begin
        if (rst || abort) begin
            count   <= '0;
            partial <= '0;
        end else if (beat_valid) begin
            count   <= at_last ? '0 : count + CNT_W'(1);
            partial <= {beat_data, partial[PART_W-1:ps_axis_width]};
        end
    end

endmodule

// File: rtl/dac_waveform_player.sv
// Loads a waveform from the PS into on-chip RAM and replays it to the RF-DAC
// on a trigger edge, one-shot or looped.
module dac_waveform_player
    import rfsoc_config::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [15:0]                  gpio_ctrl_ext,
    input  logic [ps_axis_width-1:0]     s_axis_tdata,
    input  logic                         s_axis_tvalid,
    output logic                         s_axis_tready,
    output logic [dac_word_width-1:0]    m_axis_tdata,
    output logic                         m_axis_tvalid,
    input  logic                         m_axis_tready,
    input  logic                         select_in,
    output logic                         play_active,
    output logic [ADDR_W:0]              loaded_words
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] FULL = (ADDR_W + 1)'(DEPTH);

    logic [15:0]               gpio_ctrl;
    logic                      trig_prev;
    logic                      trigger;
    dac_play_state_t           state;
    logic [ADDR_W:0]           wr_ptr;
    logic [ADDR_W-1:0]         rd_ptr;
    logic                      out_loaded;
    logic                      out_last;
    logic [ADDR_W:0]           last_idx;
    logic                      rd_at_last;
    logic                      beat_hs;
    logic                      pack_abort;
    logic                      word_valid;
    logic [dac_word_width-1:0] word_data;
    logic                      unused_gpio;

    logic [dac_word_width-1:0] ram [DEPTH];

    assign unused_gpio   = &{1'b0, gpio_ctrl[15:4]};
    assign trigger       = gpio_ctrl[trigger_line] && !trig_prev;
    assign last_idx      = wr_ptr - (ADDR_W + 1)'(1);
    assign rd_at_last    = ({1'b0, rd_ptr} == last_idx);
    assign s_axis_tready = (state == LOAD) && (wr_ptr != FULL);
    assign beat_hs       = s_axis_tvalid && s_axis_tready;
    assign pack_abort    = (state != LOAD) || gpio_ctrl[dac_buffer_clear];
    assign m_axis_tvalid = 1'b1;
    assign play_active   = (state == PLAY);
    assign loaded_words  = wr_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            gpio_ctrl <= '0;
            trig_prev <= 1'b0;
        end else begin
            gpio_ctrl <= gpio_ctrl_ext;
            trig_prev <= gpio_ctrl[trigger_line];
        end
    end

    dac_beat_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .abort      (pack_abort),
        .beat_valid (beat_hs),
        .beat_data  (s_axis_tdata),
        .word_valid (word_valid),
        .word_data  (word_data)
    );

    always_ff @(posedge clk) begin
        if (word_valid)
            ram[wr_ptr[ADDR_W-1:0]] <= word_data;
    end

    // The output register is fetched whenever it is empty or its word is being
    // accepted, so backpressure simply freezes both tdata and rd_ptr.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            out_loaded   <= 1'b0;
            out_last     <= 1'b0;
            m_axis_tdata <= '0;
        end else if (gpio_ctrl[dac_buffer_clear]) begin
            state        <= IDLE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            out_loaded   <= 1'b0;
            out_last     <= 1'b0;
            m_axis_tdata <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (gpio_ctrl[dac_load_enable]) begin
                        state  <= LOAD;
                        wr_ptr <= '0;
                    end else if (select_in && wr_ptr != '0) begin
                        state <= ARMED;
                    end
                end
                LOAD: begin
                    if (word_valid)
                        wr_ptr <= wr_ptr + (ADDR_W + 1)'(1);
                    if (!gpio_ctrl[dac_load_enable])
                        state <= IDLE;
                end
                ARMED: begin
                    if (!select_in) begin
                        state <= IDLE;
                    end else if (trigger) begin
                        state      <= PLAY;
                        rd_ptr     <= '0;
                        out_loaded <= 1'b0;
                    end
                end
                PLAY: begin
                    if (!select_in) begin
                        state        <= IDLE;
                        out_loaded   <= 1'b0;
                        m_axis_tdata <= '0;
                    end else if (out_loaded && out_last && m_axis_tready
                                 && !gpio_ctrl[dac_loop_mode]) begin
                        state        <= ARMED;
                        out_loaded   <= 1'b0;
                        m_axis_tdata <= '0;
                    end else if (!out_loaded || m_axis_tready) begin
                        m_axis_tdata <= ram[rd_ptr];
                        out_loaded   <= 1'b1;
                        out_last     <= rd_at_last;
                        rd_ptr       <= rd_at_last ? '0 : rd_ptr + ADDR_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dac_waveform_player.sv
// Directed bench for dac_waveform_player with a 16-word buffer and 32-bit beats.
module tb_dac_waveform_player;
    import rfsoc_config::*;

    localparam int AW = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [15:0]  gpio = '0;
    logic [31:0]  s_data = '0;
    logic         s_valid = 1'b0;
    logic         s_tready;
    logic [127:0] m_tdata;
    logic         m_tvalid;
    logic         m_tready = 1'b1;
    logic         sel = 1'b0;
    logic         play;
    logic [AW:0]  loaded;

    int n_checks = 0;
    int n_pass   = 0;

    dac_waveform_player #(.ADDR_W(AW)) dut (
        .clk           (clk),
        .rst           (rst),
        .gpio_ctrl_ext (gpio),
        .s_axis_tdata  (s_data),
        .s_axis_tvalid (s_valid),
        .s_axis_tready (s_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .select_in     (sel),
        .play_active   (play),
        .loaded_words  (loaded)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         tready;
        logic [127:0] data;
        logic         play;
    } vec_t;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] mkword(input logic [31:0] b);
        return {b + 32'd3, b + 32'd2, b + 32'd1, b};
    endfunction

    task automatic load_beats(input int n, input logic [31:0] base, output int accepted);
        int  stall;
        logic hs;
        gpio[dac_load_enable] = 1'b1;
        tick();
        tick();
        accepted = 0;
        stall    = 0;
        while (accepted < n && stall < 8) begin
            s_data  = base + 32'(accepted);
            s_valid = 1'b1;
            hs      = s_tready;
            tick();
            if (hs) accepted++;
            else stall++;
        end
        s_valid = 1'b0;
    endtask

    task automatic end_load();
        gpio[dac_load_enable] = 1'b0;
        tick();
        tick();
    endtask

    // Leaves the bench in cycle T, the cycle the trigger line rises.
    task automatic arm_and_fire();
        gpio[trigger_line] = 1'b0;
        sel = 1'b1;
        tick();
        gpio[trigger_line] = 1'b1;
    endtask

    initial begin
        vec_t tv [6];
        int   acc;
        int   idx;
        int   cyc;
        logic r;
        logic [127:0] w0;
        logic [127:0] w1;

        repeat (3) tick();
        chk("rst_tready", 128'(s_tready), 128'd0);
        chk("rst_tvalid", 128'(m_tvalid), 128'd1);
        chk("rst_tdata",  m_tdata, 128'd0);
        chk("rst_play",   128'(play), 128'd0);
        chk("rst_loaded", 128'(loaded), 128'd0);
        rst = 1'b0;
        tick();

        // one-shot playback of two words
        load_beats(8, 32'h1, acc);
        chk("t1_loaded", 128'(loaded), 128'd2);
        end_load();
        w0 = 128'h00000004_00000003_00000002_00000001;
        w1 = mkword(32'h5);
        tv[0] = '{1'b1, 128'd0, 1'b0};
        tv[1] = '{1'b1, 128'd0, 1'b1};
        tv[2] = '{1'b1, w0,     1'b1};
        tv[3] = '{1'b1, w1,     1'b1};
        tv[4] = '{1'b1, 128'd0, 1'b0};
        tv[5] = '{1'b1, 128'd0, 1'b0};
        arm_and_fire();
        for (int i = 0; i < 6; i++) begin
            m_tready = tv[i].tready;
            tick();
            chk($sformatf("t1_data_%0d", i + 1), m_tdata, tv[i].data);
            chk($sformatf("t1_play_%0d", i + 1), 128'(play), 128'(tv[i].play));
        end

        // looped playback, then clear mid-play
        gpio[dac_loop_mode] = 1'b1;
        arm_and_fire();
        repeat (3) tick();
        chk("t2_first", m_tdata, w0);
        for (int k = 1; k < 6; k++) begin
            tick();
            chk($sformatf("t2_loop_%0d", k), m_tdata, (k % 2 == 1) ? w1 : w0);
        end
        gpio[dac_buffer_clear] = 1'b1;
        tick();
        tick();
        chk("t2_clr_data",   m_tdata, 128'd0);
        chk("t2_clr_play",   128'(play), 128'd0);
        chk("t2_clr_loaded", 128'(loaded), 128'd0);
        gpio[dac_buffer_clear] = 1'b0;
        gpio[dac_loop_mode]    = 1'b0;
        tick();
        tick();

        // partial word discarded, single-word replay, gated triggers
        load_beats(6, 32'h11, acc);
        end_load();
        chk("t5_loaded", 128'(loaded), 128'd1);
        arm_and_fire();
        repeat (3) tick();
        chk("t5_word", m_tdata, mkword(32'h11));
        tick();
        chk("t5_after", m_tdata, 128'd0);
        sel = 1'b0;
        gpio[trigger_line] = 1'b0;
        tick();
        gpio[trigger_line] = 1'b1;
        repeat (5) tick();
        chk("t5_nosel_play", 128'(play), 128'd0);
        chk("t5_nosel_data", m_tdata, 128'd0);
        gpio[trigger_line] = 1'b0;
        sel = 1'b1;
        tick();
        gpio[trigger_line]     = 1'b1;
        gpio[dac_buffer_clear] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("t5_clrwin_play_%0d", k), 128'(play), 128'd0);
        end
        chk("t5_clrwin_loaded", 128'(loaded), 128'd0);
        chk("t5_clrwin_data",   m_tdata, 128'd0);
        gpio[dac_buffer_clear] = 1'b0;
        gpio[trigger_line]     = 1'b0;
        tick();
        tick();

        // overfill a 16-word buffer and replay it
        load_beats(70, 32'h1, acc);
        chk("t3_accepted", 128'(acc), 128'd64);
        chk("t3_tready",   128'(s_tready), 128'd0);
        chk("t3_loaded",   128'(loaded), 128'd16);
        end_load();
        arm_and_fire();
        tick();
        tick();
        for (int k = 0; k < 16; k++) begin
            tick();
            chk($sformatf("t3_word_%0d", k), m_tdata, mkword(32'(4 * k + 1)));
        end
        tick();
        chk("t3_end_data", m_tdata, 128'd0);
        chk("t3_end_play", 128'(play), 128'd0);

        // random backpressure must neither drop nor repeat words
        arm_and_fire();
        repeat (3) tick();
        idx = 0;
        cyc = 0;
        while (idx < 16 && cyc < 400) begin
            r = 1'($urandom_range(0, 1));
            m_tready = r;
            if (r) begin
                chk($sformatf("t4_word_%0d", idx), m_tdata, mkword(32'(4 * idx + 1)));
                idx++;
            end
            tick();
            cyc++;
        end
        m_tready = 1'b1;
        chk("t4_count", 128'(idx), 128'd16);
        chk("t4_end_play", 128'(play), 128'd0);

        // reset in the middle of looped playback
        gpio[dac_loop_mode] = 1'b1;
        arm_and_fire();
        repeat (4) tick();
        chk("t6_playing", 128'(play), 128'd1);
        rst = 1'b1;
        tick();
        chk("t6_play",   128'(play), 128'd0);
        chk("t6_data",   m_tdata, 128'd0);
        chk("t6_loaded", 128'(loaded), 128'd0);
        chk("t6_tready", 128'(s_tready), 128'd0);
        rst = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
